phase_timer: RTL and testbench
==============================

Name: phase_timer

Overview:
- Seconds time base and phase timer that drives the traffic-light state FSM directly upstream of it.
- Divides clk1 down to a 1 s tick and runs a repeating half-cycle second counter of CYCLE_S seconds.
- Emits single-cycle pulses timeout25 (green phase ends) and timeout30 (yellow phase ends, half-cycle wraps), which the FSM consumes.
- Also provides a BCD countdown of seconds remaining in the current phase for the two-digit 7-segment displays.

Parameters:
- DIV, 50_000_000, clk1 cycles per second tick (>=1).
- GREEN_S, 25, seconds from half-cycle start to timeout25 (>=1).
- CYCLE_S, 30, seconds from half-cycle start to timeout30 (GREEN_S < CYCLE_S <= 99).

Ports:
- clk1  in  1  system clock, sole clock.
- rst  in  1  synchronous, active-low reset.
- run  in  1  count enable; low freezes all counters.
- timeout25  out  1  one-cycle pulse at end of green phase.
- timeout30  out  1  one-cycle pulse at end of yellow phase and half-cycle wrap.
- rem_tens  out  4  BCD tens digit of seconds remaining in phase.
- rem_ones  out  4  BCD ones digit of seconds remaining in phase.

Behaviour:
- Reset (rst==0 at a clk1 rising edge):
  - div_cnt=0, sec=0, timeout25=0, timeout30=0, rem_tens=GREEN_S/10, rem_ones=GREEN_S%10 (defaults give 2, 5).
  - Reset wins over every other event in that cycle.
  - Reset asserted mid-count aborts the phase; no pulse is emitted.
- Prescaler:
  - div_cnt counts 0..DIV-1 while run=1 and wraps to 0.
  - sec_tick = run && (div_cnt==DIV-1), combinational and internal.
  - DIV=1 gives sec_tick on every run cycle.
- Second counter:
  - sec counts 0..CYCLE_S-1 and advances only on sec_tick.
  - At CYCLE_S-1, a sec_tick wraps sec to 0.
- Pulses (registered, with the same edge that updates sec):
  - timeout25 is 1 for exactly one cycle after the edge where sec_tick && sec==GREEN_S-1; otherwise 0.
  - timeout30 is 1 for exactly one cycle after the edge where sec_tick && sec==CYCLE_S-1; otherwise 0.
  - The two pulses are never high together.
  - Back-to-back pulses are impossible for DIV>=2. With DIV=1 pulses may be adjacent but still last one cycle each.
- Remaining-time display:
  - remaining = (sec<GREEN_S) ? GREEN_S-sec : CYCLE_S-sec, range 1..max(GREEN_S, CYCLE_S-GREEN_S).
  - Digits are registered from the next value of sec, so they change on the same edge as sec.
  - Defaults: sec 0→25, 24→1, 25→5, 29→1.
- run=0:
  - div_cnt, sec and digits hold.
  - Pulses forced to 0; a pulse already high drops after one cycle as normal.
  - Resuming continues the count exactly where it stopped.
- Widths:
  - div_cnt is $clog2(DIV) bits (min 1); sec is 7 bits.
  - All compares are unsigned; no overflow is possible.
- No internal knowledge of FSM state. Alignment with the FSM relies on both blocks leaving reset together.

Decomposition:
- Shared package tl_pkg: default constants (DIV_1HZ, GREEN_S, CYCLE_S) and the bcd_t 4-bit typedef, also used by the 7-seg driver.
- One natural sub-module: bin2bcd_2dig, combinational 7-bit binary (0..99) to two BCD digits, instantiated once on remaining_next.
- Parameter legality is checked by elaboration-time assertions.

Test Plan:
- Reset, DIV=4: hold rst=0 for 3 cycles, then release → rem_tens=2, rem_ones=5, both timeouts 0; sec=1 and digits 2,4 after edge 4.
- Full half-cycle, DIV=4, run=1: timeout25 high only in the cycle after edge 100 (digits 0,5); timeout30 high only in the cycle after edge 120 (sec=0, digits 2,5); each pulse is exactly 1 cycle wide.
- Repetition: run 3 half-cycles → timeout25 at edges 100/220/340 and timeout30 at 120/240/360; the pulses never overlap.
- Pause: drop run for 17 cycles at edge 50 → all pulse edges shift by exactly 17, digits frozen during the pause, no pulses while run=0.
- Reset mid-phase: assert rst=0 at edge 110 (yellow) → no timeout30; outputs return to 2,5; next timeout25 at 100 edges after release.
- DIV=1, GREEN_S=1, CYCLE_S=2: timeout25 and timeout30 alternate every cycle, each 1 cycle wide; digits stay 0,1.

Source files
------------

// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tl_pkg
//  Purpose  : Shared constants and types for the traffic-light blocks.
//             DIV_1HZ : clk1 cycles per one-second tick
//             GREEN_S : seconds from half-cycle start to end of green
//             CYCLE_S : seconds in one half-cycle (green + yellow)
//             bcd_t   : one BCD digit, also used by the 7-segment driver
//  Revision : 1.0  initial release
// ============================================================================
package tl_pkg;

  localparam int DIV_1HZ = 50_000_000;
  localparam int GREEN_S = 25;
  localparam int CYCLE_S = 30;

  typedef logic [3:0] bcd_t;

endpackage
`default_nettype wire

// File: rtl/bin2bcd_2dig.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_2dig
//  Purpose  : Combinational 7-bit binary (0..99) to two BCD digits.
//  Ports    : bin   in  7  binary value, 0..99
//             tens  out 4  BCD tens digit
//             ones  out 4  BCD ones digit
//  Revision : 1.0  initial release
// ============================================================================
module bin2bcd_2dig
  import tl_pkg::*;
(
  input  logic [6:0] bin,
  output bcd_t       tens,
  output bcd_t       ones
);

  // Inputs never exceed 99, so the quotient and remainder both fit in 4 bits.
  always_comb begin
    tens = 4'(bin / 7'd10);
    ones = 4'(bin % 7'd10);
  end

endmodule
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
//  Module   : phase_timer
//  Purpose  : One-second time base plus repeating half-cycle phase timer.
//             Emits one-cycle pulses at end of green (timeout25) and end of
//             yellow / half-cycle wrap (timeout30), and a BCD countdown of
//             seconds remaining in the current phase.
//  Ports    : clk1      in  1  system clock
//             rst       in  1  synchronous, active-low reset
//             run       in  1  count enable; low freezes all counters
//             timeout25 out 1  one-cycle pulse, end of green phase
//             timeout30 out 1  one-cycle pulse, end of yellow phase
//             rem_tens  out 4  BCD tens of seconds remaining in phase
//             rem_ones  out 4  BCD ones of seconds remaining in phase
//  Revision : 1.0  initial release
// ============================================================================
module phase_timer
  import tl_pkg::*;
#(
  parameter int DIV     = tl_pkg::DIV_1HZ,
  parameter int GREEN_S = tl_pkg::GREEN_S,
  parameter int CYCLE_S = tl_pkg::CYCLE_S
) (
  input  logic clk1,
  input  logic rst,
  input  logic run,
  output logic timeout25,
  output logic timeout30,
  output bcd_t rem_tens,
  output bcd_t rem_ones
);

  // Parameter legality, checked at elaboration.
  if (DIV < 1) begin : g_bad_div
    $error("phase_timer: DIV must be >= 1");
  end
  if (GREEN_S < 1) begin : g_bad_green
    $error("phase_timer: GREEN_S must be >= 1");
  end
  if ((CYCLE_S <= GREEN_S) || (CYCLE_S > 99)) begin : g_bad_cycle
    $error("phase_timer: need GREEN_S < CYCLE_S <= 99");
  end

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] c_div_last   = DIV_W'(DIV - 1);
  localparam logic [6:0]       c_green      = 7'(GREEN_S);
  localparam logic [6:0]       c_cycle      = 7'(CYCLE_S);
  localparam logic [6:0]       c_green_last = 7'(GREEN_S - 1);
  localparam logic [6:0]       c_cycle_last = 7'(CYCLE_S - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [6:0]       r_sec;
  logic             r_t25;
  logic             r_t30;
  bcd_t             r_rem_tens;
  bcd_t             r_rem_ones;

  logic             w_sec_tick;
  logic [6:0]       w_sec_next;
  logic [6:0]       w_rem_next;
  bcd_t             w_tens_next;
  bcd_t             w_ones_next;

  always_comb begin
    w_sec_tick = run && (r_div_cnt == c_div_last);

    w_sec_next = r_sec;
    if (w_sec_tick) begin
      w_sec_next = (r_sec == c_cycle_last) ? 7'd0 : r_sec + 7'd1;
    end

    // Digits follow the value sec is about to take, so display and counter
    // change on the same edge.
    w_rem_next = (w_sec_next < c_green) ? (c_green - w_sec_next)
                                        : (c_cycle - w_sec_next);
  end

  bin2bcd_2dig u_bcd (
    .bin  (w_rem_next),
    .tens (w_tens_next),
    .ones (w_ones_next)
  );

  always_ff @(posedge clk1) begin
    if (!rst) begin
      r_div_cnt  <= '0;
      r_sec      <= 7'd0;
      r_t25      <= 1'b0;
      r_t30      <= 1'b0;
      r_rem_tens <= 4'(GREEN_S / 10);
      r_rem_ones <= 4'(GREEN_S % 10);
    end else begin
      if (run) begin
        r_div_cnt <= (r_div_cnt == c_div_last) ? '0 : r_div_cnt + 1'b1;
      end
      r_sec      <= w_sec_next;
      // Gating by sec_tick also forces both pulses low while run is low.
      r_t25      <= w_sec_tick && (r_sec == c_green_last);
      r_t30      <= w_sec_tick && (r_sec == c_cycle_last);
      r_rem_tens <= w_tens_next;
      r_rem_ones <= w_ones_next;
    end
  end

  assign timeout25 = r_t25;
  assign timeout30 = r_t30;
  assign rem_tens  = r_rem_tens;
  assign rem_ones  = r_rem_ones;

endmodule
`default_nettype wire

// File: tb/tb_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phase_timer
//  Purpose  : Directed self-checking bench for phase_timer. Two instances
//             share clock, reset and run: one with DIV=4 / 25 / 30, one with
//             DIV=1 / 1 / 2. A per-instance count of enabled edges since
//             reset gives the expected second count, pulses and digits.
//  Revision : 1.0  initial release
// ============================================================================
module tb_phase_timer;

  logic       clk1;
  logic       rst;
  logic       run;

  logic       a_t25, a_t30;
  logic [3:0] a_tens, a_ones;
  logic       b_t25, b_t30;
  logic [3:0] b_tens, b_ones;

  int n_checks = 0;
  int n_errors = 0;
  int act      = 0;   // enabled edges since last reset
  int edge_n   = 0;   // edges since last reset release (for tags)

  phase_timer #(.DIV(4), .GREEN_S(25), .CYCLE_S(30)) dut_a (
    .clk1      (clk1),
    .rst       (rst),
    .run       (run),
    .timeout25 (a_t25),
    .timeout30 (a_t30),
    .rem_tens  (a_tens),
    .rem_ones  (a_ones)
  );

  phase_timer #(.DIV(1), .GREEN_S(1), .CYCLE_S(2)) dut_b (
    .clk1      (clk1),
    .rst       (rst),
    .run       (run),
    .timeout25 (b_t25),
    .timeout30 (b_t30),
    .rem_tens  (b_tens),
    .rem_ones  (b_ones)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, edge_n, obs, exp);
    end
  endtask

  // One clock: sample the driven inputs, advance the model, check both DUTs.
  task automatic cycle();
    logic ran;
    int   s, rem;
    ran = rst && run;
    @(posedge clk1);
    #1;
    if (!rst) begin
      act    = 0;
      edge_n = 0;
    end else begin
      edge_n++;
      if (ran) act++;
    end

    // DIV=4, GREEN 25, CYCLE 30: one second per 4 enabled edges.
    s   = (act / 4) % 30;
    rem = (s < 25) ? (25 - s) : (30 - s);
    check("a_t25", int'(a_t25), (ran && (act % 120) == 100) ? 1 : 0);
    check("a_t30", int'(a_t30), (ran && (act % 120) == 0)   ? 1 : 0);
    check("a_tens", int'(a_tens), rem / 10);
    check("a_ones", int'(a_ones), rem % 10);
    check("a_overlap", int'(a_t25 & a_t30), 0);

    // DIV=1, GREEN 1, CYCLE 2: pulses alternate, display is always 01.
    check("b_t25", int'(b_t25), (ran && (act % 2) == 1) ? 1 : 0);
    check("b_t30", int'(b_t30), (ran && (act % 2) == 0) ? 1 : 0);
    check("b_tens", int'(b_tens), 0);
    check("b_ones", int'(b_ones), 1);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b0;
    run = 1'b1;

    // Reset held three cycles: digits 2,5 and no pulses.
    cycles(3);
    check("rst_tens", int'(a_tens), 2);
    check("rst_ones", int'(a_ones), 5);
    check("rst_t25",  int'(a_t25), 0);
    check("rst_t30",  int'(a_t30), 0);

    // Release; first second elapses at edge 4 (digits 2,4).
    rst = 1'b1;
    cycles(4);
    check("e4_tens", int'(a_tens), 2);
    check("e4_ones", int'(a_ones), 4);

    // Three full half-cycles: pulses at 100/220/340 and 120/240/360.
    cycles(96);
    check("e100_t25",  int'(a_t25), 1);
    check("e100_ones", int'(a_ones), 5);
    cycles(20);
    check("e120_t30",  int'(a_t30), 1);
    check("e120_tens", int'(a_tens), 2);
    cycles(240);

    // Pause: run low for 17 cycles after edge 50, green end moves to 117.
    rst = 1'b0;
    cycles(2);
    rst = 1'b1;
    cycles(50);
    run = 1'b0;
    cycles(17);
    run = 1'b1;
    cycles(49);
    check("pause_pre117_t25", int'(a_t25), 0);
    cycle();
    check("pause_e117_t25", int'(a_t25), 1);
    cycles(40);

    // Reset in yellow at edge 110: no timeout30, display back to 2,5.
    rst = 1'b0;
    cycles(2);
    rst = 1'b1;
    cycles(110);
    rst = 1'b0;
    cycles(2);
    check("midrst_tens", int'(a_tens), 2);
    check("midrst_ones", int'(a_ones), 5);
    check("midrst_t30",  int'(a_t30), 0);
    rst = 1'b1;
    cycles(100);
    check("midrst_e100_t25", int'(a_t25), 1);
    cycles(25);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
